// File: rtl/jtframe_pal_pkg.sv
// Shared constants, derivation helpers and sequencer states for the palette mixer.
package jtframe_pal_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned LNW   = $clog2(LANES);

  typedef enum logic {
    ST_IDLE,
    ST_READ
  } seq_state_t;

  function automatic int unsigned calc_nb(input int unsigned cw);
    return (3 * cw + 7) / 8;
  endfunction

  function automatic int unsigned calc_lyw(input int unsigned layers);
    return (layers > 1) ? $clog2(layers) : 1;
  endfunction

  function automatic int unsigned calc_ew(input int unsigned bankw, input int unsigned lyw,
                                          input int unsigned lw);
    return bankw + lyw + lw;
  endfunction

  function automatic int unsigned shadow_code(input int unsigned lw);
    return (1 << lw) - 2;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM: port A read/write, port B read-only, read-before-write on collisions.
module jtframe_dual_ram #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr_a,
  input  logic          i_we_a,
  input  logic [DW-1:0] i_data_a,
  output logic [DW-1:0] o_q_a,
  input  logic [AW-1:0] i_addr_b,
  output logic [DW-1:0] o_q_b
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_data_a;
    o_q_a <= r_mem[i_addr_a];
    o_q_b <= r_mem[i_addr_b];
  end

endmodule

// File: rtl/jtframe_pal_prio.sv
// Layer priority encoder: layer 0 wins, transparent pixels (low TW bits all ones) fall through.
module jtframe_pal_prio
  import jtframe_pal_pkg::*;
#(
  parameter int unsigned LAYERS = 2,
  parameter int unsigned LW     = 8,
  parameter int unsigned TW     = 4,
  localparam int unsigned LYW   = calc_lyw(LAYERS)
) (
  input  logic [LAYERS*LW-1:0] i_pxl,
  output logic [LW-1:0]        o_pxl_c,
  output logic [LYW-1:0]       o_lyr_c
);

  // Scan from the last layer upwards so the lowest opaque layer is the final assignment.
  always_comb begin
    o_pxl_c = i_pxl[(LAYERS-1)*LW +: LW];
    o_lyr_c = LYW'(LAYERS - 1);
    for (int k = int'(LAYERS) - 1; k >= 0; k--) begin
      if (i_pxl[k*LW +: TW] != {TW{1'b1}}) begin
        o_pxl_c = i_pxl[k*LW +: LW];
        o_lyr_c = LYW'(k);
      end
    end
  end

endmodule

// File: rtl/jtframe_pal_mixer.sv
// Layer mixer with byte-wide palette RAM and per-pixel lane read sequencer.
// Optional shadow pixels on layer 0 when JTFRAME_PAL_SHADOW_EN is defined.
module jtframe_pal_mixer
  import jtframe_pal_pkg::*;
#(
  parameter int unsigned CW     = 4,
  parameter int unsigned LAYERS = 2,
  parameter int unsigned LW     = 8,
  parameter int unsigned TW     = 4,
  parameter int unsigned BANKW  = 1,
  localparam int unsigned NB    = calc_nb(CW),
  localparam int unsigned LYW   = calc_lyw(LAYERS),
  localparam int unsigned EW    = calc_ew(BANKW, LYW, LW),
  localparam int unsigned CAW   = EW - BANKW + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pxl_cen,
  input  logic                 LHBL,
  input  logic                 LVBL,
  input  logic [LAYERS*LW-1:0] lyr_pxl,
  input  logic [BANKW-1:0]     pal_bank,
  input  logic                 pal_cs,
  input  logic                 wr_n,
  input  logic [CAW-1:0]       cpu_addr,
  input  logic [7:0]           cpu_dout,
  output logic [7:0]           pal_dout,
  output logic [CW-1:0]        red,
  output logic [CW-1:0]        green,
  output logic [CW-1:0]        blue,
  output logic                 LHBL_dly,
  output logic                 LVBL_dly,
  output logic                 seq_ovf
);

  localparam int unsigned AW  = EW + 2;
  localparam int unsigned WW  = NB * 8;
  localparam int unsigned CCW = 3 * CW;
  localparam logic [LNW-1:0] NB_L   = LNW'(NB);
  localparam logic [LNW-1:0] LAST_L = LNW'(NB - 1);

  logic [LAYERS*LW-1:0] w_lyr_pxl;
  logic [LW-1:0]        w_sel_pxl;
  logic [LYW-1:0]       w_sel_lyr;
  logic [EW-1:0]        w_entry;
  logic [LNW-1:0]       w_cpu_lane;
  logic [AW-1:0]        w_cpu_addr, w_vid_addr;
  logic                 w_cpu_we;
  logic [7:0]           w_q_a, w_q_b;
  logic [CCW-1:0]       w_col;
  logic [CW-1:0]        w_r, w_g, w_b;

  seq_state_t           r_state;
  logic [LNW-1:0]       r_lane, r_st_lane;
  logic                 r_st_vld;
  logic [EW-1:0]        r_entry;
  logic [WW-1:0]        r_word;
  logic                 r_hb, r_vb, r_rd_zero;

`ifdef JTFRAME_PAL_SHADOW_EN
  logic w_shadow, r_shd;

  // A shadow pixel is forced transparent so priority falls through to the layer below.
  assign w_shadow = (lyr_pxl[LW-1:0] == LW'(shadow_code(LW)));
  always_comb begin
    w_lyr_pxl = lyr_pxl;
    if (w_shadow) w_lyr_pxl[LW-1:0] = {LW{1'b1}};
  end
`else
  assign w_lyr_pxl = lyr_pxl;
`endif

  jtframe_pal_prio #(
    .LAYERS (LAYERS),
    .LW     (LW),
    .TW     (TW)
  ) u_prio (
    .i_pxl   (w_lyr_pxl),
    .o_pxl_c (w_sel_pxl),
    .o_lyr_c (w_sel_lyr)
  );

  assign w_entry    = {pal_bank, w_sel_lyr, w_sel_pxl};
  assign w_cpu_lane = cpu_addr[1:0];
  assign w_cpu_addr = {w_cpu_lane, pal_bank, cpu_addr[CAW-1:2]};
  assign w_cpu_we   = pal_cs & ~wr_n & (w_cpu_lane < NB_L);
  assign w_vid_addr = {r_lane, r_entry};
  assign pal_dout   = r_rd_zero ? 8'd0 : w_q_a;

  jtframe_dual_ram #(
    .DW (8),
    .AW (AW)
  ) u_ram (
    .clk      (clk),
    .i_addr_a (w_cpu_addr),
    .i_we_a   (w_cpu_we),
    .i_data_a (cpu_dout),
    .o_q_a    (w_q_a),
    .i_addr_b (w_vid_addr),
    .o_q_b    (w_q_b)
  );

  always_comb begin
    w_col = CCW'(r_word);
    {w_r, w_g, w_b} = w_col;
`ifdef JTFRAME_PAL_SHADOW_EN
    if (r_shd) begin
      w_r = w_r >> 1;
      w_g = w_g >> 1;
      w_b = w_b >> 1;
    end
`endif
  end

  // Sequencer: issue lane n one clk, store its byte the next; pxl_cen restarts and cancels the issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lane    <= '0;
      r_st_lane <= '0;
      r_st_vld  <= 1'b0;
      r_entry   <= '0;
      r_word    <= '0;
      r_hb      <= 1'b0;
      r_vb      <= 1'b0;
      r_rd_zero <= 1'b1;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      LHBL_dly  <= 1'b0;
      LVBL_dly  <= 1'b0;
      seq_ovf   <= 1'b0;
`ifdef JTFRAME_PAL_SHADOW_EN
      r_shd     <= 1'b0;
`endif
    end else begin
      r_rd_zero <= (w_cpu_lane >= NB_L);
      r_st_vld  <= 1'b0;
      for (int n = 0; n < int'(NB); n++) begin
        if (r_st_vld && r_st_lane == LNW'(n)) r_word[n*8 +: 8] <= w_q_b;
      end
      if (r_state == ST_READ) begin
        if (r_lane < NB_L) begin
          r_st_vld  <= 1'b1;
          r_st_lane <= r_lane;
          r_lane    <= r_lane + LNW'(1);
        end else if (r_st_vld && r_st_lane == LAST_L) begin
          r_state <= ST_IDLE;
        end
      end
      if (pxl_cen) begin
        if (r_state == ST_READ) seq_ovf <= 1'b1;
        r_state  <= ST_READ;
        r_lane   <= '0;
        r_st_vld <= 1'b0;
        r_entry  <= w_entry;
        r_hb     <= LHBL;
        r_vb     <= LVBL;
        LHBL_dly <= r_hb;
        LVBL_dly <= r_vb;
`ifdef JTFRAME_PAL_SHADOW_EN
        r_shd    <= w_shadow;
`endif
        if (r_hb && r_vb) begin
          red   <= w_r;
          green <= w_g;
          blue  <= w_b;
        end else begin
          red   <= '0;
          green <= '0;
          blue  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_pal_mixer.sv
// Bench for jtframe_pal_mixer: CW=4 instance for mixing/blanking, CW=8 instance for overrun.
module tb_jtframe_pal_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pxl_cen, pxl_cen2, LHBL, LVBL, pal_bank, pal_cs, wr_n;
  logic [15:0] lyr_pxl;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  pal_dout1, pal_dout2;
  logic [3:0]  red1, green1, blue1;
  logic [7:0]  red2, green2, blue2;
  logic        hb1, vb1, hb2, vb2, ovf1, ovf2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pal_m [1024][3];

  jtframe_pal_mixer #(.CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .lyr_pxl(lyr_pxl), .pal_bank(pal_bank), .pal_cs(pal_cs), .wr_n(wr_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout1),
    .red(red1), .green(green1), .blue(blue1),
    .LHBL_dly(hb1), .LVBL_dly(vb1), .seq_ovf(ovf1)
  );

  jtframe_pal_mixer #(.CW(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen2), .LHBL(LHBL), .LVBL(LVBL),
    .lyr_pxl(lyr_pxl), .pal_bank(pal_bank), .pal_cs(pal_cs), .wr_n(wr_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout2),
    .red(red2), .green(green2), .blue(blue2),
    .LHBL_dly(hb2), .LVBL_dly(vb2), .seq_ovf(ovf2)
  );

  typedef struct {
    logic [7:0]  l0;
    logic [7:0]  l1;
    logic        bank;
    logic        hb;
    logic        vb;
    logic [13:0] exp;
    string       name;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pixel_step(input int per, input bit second);
    if (second) pxl_cen2 = 1'b1; else pxl_cen = 1'b1;
    step();
    pxl_cen  = 1'b0;
    pxl_cen2 = 1'b0;
    repeat (per - 1) step();
  endtask

  task automatic wr(input logic [9:0] e, input logic [1:0] lane, input logic [7:0] d);
    pal_bank = e[9];
    cpu_addr = {e[8:0], lane};
    cpu_dout = d;
    pal_cs   = 1'b1;
    wr_n     = 1'b0;
    step();
    pal_cs   = 1'b0;
    wr_n     = 1'b1;
    if (lane < 2'd3) pal_m[e][lane] = d;
  endtask

  task automatic set_pix(input logic [7:0] l0, input logic [7:0] l1, input logic bank,
                         input logic hb, input logic vb);
    lyr_pxl  = {l1, l0};
    pal_bank = bank;
    LHBL     = hb;
    LVBL     = vb;
  endtask

  // Expected {R,G,B,LHBL_dly,LVBL_dly} for the CW=4 instance, from the mixing rules.
  function automatic logic [13:0] ref_out(input logic [7:0] l0, input logic [7:0] l1,
                                          input logic bank, input logic hb, input logic vb);
    logic [7:0]  px;
    logic        lyr, shd;
    logic [9:0]  e;
    logic [15:0] c16;
    logic [3:0]  r, g, b;
    shd = 1'b0;
`ifdef JTFRAME_PAL_SHADOW_EN
    shd = (l0 == 8'hFE);
`endif
    if (!shd && l0[3:0] != 4'hF) begin
      lyr = 1'b0; px = l0;
    end else begin
      lyr = 1'b1; px = l1;
    end
    e   = {bank, lyr, px};
    c16 = {pal_m[e][1], pal_m[e][0]};
    r = c16[11:8]; g = c16[7:4]; b = c16[3:0];
    if (shd) begin
      r = r / 2; g = g / 2; b = b / 2;
    end
    if (!(hb && vb)) begin
      r = 4'd0; g = 4'd0; b = 4'd0;
    end
    return {r, g, b, hb, vb};
  endfunction

  function automatic logic [13:0] out1();
    return {red1, green1, blue1, hb1, vb1};
  endfunction

  initial begin
    vec_t        vecs[6];
    logic [13:0] exp_q[$];
    logic [13:0] e_now;
    logic [7:0]  l0, l1;
    logic        bk, hb, vb;

    vecs[0] = '{8'h05, 8'h0F, 1'b0, 1'b1, 1'b1, {4'h3, 4'h5, 4'hA, 2'b11}, "opaque_l0"};
    vecs[1] = '{8'h1F, 8'h22, 1'b1, 1'b1, 1'b1, {4'h7, 4'hC, 4'h1, 2'b11}, "transp_l0_bank1"};
    vecs[2] = '{8'h1F, 8'h3F, 1'b0, 1'b1, 1'b1, {4'h2, 4'hD, 4'h6, 2'b11}, "all_transp"};
    vecs[3] = '{8'h05, 8'h22, 1'b0, 1'b1, 1'b0, {4'h0, 4'h0, 4'h0, 2'b10}, "vblank"};
    vecs[4] = '{8'h05, 8'h22, 1'b0, 1'b0, 1'b1, {4'h0, 4'h0, 4'h0, 2'b01}, "hblank"};
`ifdef JTFRAME_PAL_SHADOW_EN
    vecs[5] = '{8'hFE, 8'h40, 1'b0, 1'b1, 1'b1, {4'h7, 4'h4, 4'h1, 2'b11}, "shadow"};
`else
    vecs[5] = '{8'hFE, 8'h40, 1'b0, 1'b1, 1'b1, {4'h9, 4'hB, 4'h4, 2'b11}, "code_fe_plain"};
`endif

    rst_n = 1'b0; pxl_cen = 1'b0; pxl_cen2 = 1'b0; pal_cs = 1'b0; wr_n = 1'b1;
    cpu_addr = '0; cpu_dout = '0;
    set_pix(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    repeat (3) step();
    chk("reset_out1", 32'(out1()), 32'd0);
    chk("reset_ovf1", 32'(ovf1), 32'd0);
    chk("reset_out2", {red2, green2, blue2, hb2}, 32'd0);
    chk("reset_ovf2", 32'(ovf2), 32'd0);
    rst_n = 1'b1;
    step();

    wr(10'h005, 2'd0, 8'h5A); wr(10'h005, 2'd1, 8'h03);
    wr(10'h322, 2'd0, 8'hC1); wr(10'h322, 2'd1, 8'h07);
    wr(10'h13F, 2'd0, 8'hD6); wr(10'h13F, 2'd1, 8'h02);
    wr(10'h0FE, 2'd0, 8'hB4); wr(10'h0FE, 2'd1, 8'h09);
    wr(10'h140, 2'd0, 8'h82); wr(10'h140, 2'd1, 8'h0F);

    foreach (vecs[i]) begin
      set_pix(vecs[i].l0, vecs[i].l1, vecs[i].bank, vecs[i].hb, vecs[i].vb);
      pixel_step(4, 1'b0);
      pixel_step(4, 1'b0);
      chk(vecs[i].name, 32'(out1()), 32'(vecs[i].exp));
    end

    // Random palette and pixels, one pixel per 4 clk, two-pixel latency.
    for (int e = 0; e < 1024; e++)
      for (int ln = 0; ln < 3; ln++) wr(10'(e), 2'(ln), 8'($urandom));
    for (int k = 0; k < 150; k++) begin
      l0 = 8'($urandom); l1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) l0[3:0] = 4'hF;
      if ($urandom_range(0, 7) == 0) l0 = 8'hFE;
      if ($urandom_range(0, 5) == 0) l1[3:0] = 4'hF;
      bk = 1'($urandom);
      hb = ($urandom_range(0, 7) != 0);
      vb = ($urandom_range(0, 7) != 0);
      set_pix(l0, l1, bk, hb, vb);
      exp_q.push_back(ref_out(l0, l1, bk, hb, vb));
      pixel_step(4, 1'b0);
      if (exp_q.size() == 2) begin
        e_now = exp_q.pop_front();
        chk("random_pixel", 32'(out1()), 32'(e_now));
      end
    end
    chk("no_ovf_period4", 32'(ovf1), 32'd0);

    // Overrun on the 3-lane instance: period 5 is clean, period 3 leaves lane 2 stale.
    wr(10'h010, 2'd0, 8'h33); wr(10'h010, 2'd1, 8'h22); wr(10'h010, 2'd2, 8'h11);
    wr(10'h020, 2'd0, 8'h66); wr(10'h020, 2'd1, 8'h55); wr(10'h020, 2'd2, 8'h44);
    set_pix(8'h10, 8'h0F, 1'b0, 1'b1, 1'b1);
    repeat (4) pixel_step(5, 1'b1);
    chk("ovf2_period5", 32'(ovf2), 32'd0);
    chk("colour2_period5", {8'h00, red2, green2, blue2}, 32'h00112233);
    set_pix(8'h20, 8'h0F, 1'b0, 1'b1, 1'b1);
    repeat (4) pixel_step(3, 1'b1);
    chk("ovf2_period3", 32'(ovf2), 32'd1);
    chk("colour2_stale_lane2", {8'h00, red2, green2, blue2}, 32'h00115566);

    // Reset asserted for one clk while the CW=4 sequencer is mid-read.
    set_pix(8'h05, 8'h0F, 1'b0, 1'b1, 1'b1);
    pxl_cen = 1'b1;
    step();
    pxl_cen = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midread_rst_out1", 32'(out1()), 32'd0);
    chk("midread_rst_ovf1", 32'(ovf1), 32'd0);
    chk("midread_rst_ovf2", 32'(ovf2), 32'd0);
    chk("midread_rst_rgb2", {8'h00, red2, green2, blue2}, 32'd0);

    pal_bank = 1'b0;
    cpu_addr = {9'h005, 2'd3};
    step();
    chk("cpu_rd_lane3_dut1", 32'(pal_dout1), 32'd0);
    chk("cpu_rd_lane3_dut2", 32'(pal_dout2), 32'd0);
    cpu_addr = {9'h005, 2'd0};
    step();
    chk("cpu_rd_kept_lane0", 32'(pal_dout1), 32'(pal_m[10'h005][0]));
    cpu_addr = {9'h010, 2'd2};
    step();
    chk("cpu_rd_lane2_dut2", 32'(pal_dout2), 32'h11);
    chk("cpu_rd_lane2_dut1", 32'(pal_dout1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_pal_mixer.md
JTFRAME_PAL_MIXER -- requirements
Module: jtframe_pal_mixer

Interface
REQ-001 Parameter CW, default 4, bits per colour channel; legal range 4..8.
REQ-002 Parameter LAYERS, default 2, number of pixel layers; legal range 1..4.
REQ-003 Parameter LW, default 8, pixel index width per layer.
REQ-004 Parameter TW, default 4, low pixel bits tested for transparency; TW <= LW.
REQ-005 Parameter BANKW, default 1, palette bank select width.
REQ-006 Derived constants: NB = ceil(3*CW/8) bytes per entry; LYW = max(1, clog2(LAYERS)); EW = BANKW+LYW+LW entry address width.
REQ-007 Clock and reset: one clock, reset synchronous active-low. Ports: clk input 1, system clock; rst_n input 1, synchronous active-low reset.
REQ-008 Port list (name, direction, width, meaning):
- pxl_cen input 1: pixel clock enable.
- LHBL, LVBL input 1 each: active-low blanks.
- lyr_pxl input LAYERS*LW: layer k at bits [k*LW +: LW].
- pal_bank input BANKW: bank select.
- pal_cs input 1: CPU chip select.
- wr_n input 1: CPU write strobe, active low.
- cpu_addr input EW-LYW-BANKW+LYW+2: byte address {entry, lane[1:0]}.
- cpu_dout input 8: CPU write data.
- pal_dout output 8: CPU read data.
- red, green, blue output CW each: pixel colour.
- LHBL_dly, LVBL_dly output 1 each: blanks aligned to colour.
- seq_ovf output 1: sticky sequencing-overrun flag.

Function
REQ-009 Palette RAM: dual port, 8-bit, 2^(EW+2) bytes, addressed {lane, entry}; CPU port on A, video port read-only.
REQ-010 CPU write when pal_cs & ~wr_n; entry = {pal_bank, cpu_addr[EW-BANKW+1:2]}; lane = cpu_addr[1:0]; lanes >= NB are ignored on write and return 0 on read.
REQ-011 Transparency: a layer pixel is transparent when its low TW bits are all ones.
REQ-012 Priority: layer 0 is highest; the first non-transparent layer is selected; if all layers are transparent, the last layer is selected.
REQ-013 Entry index = {pal_bank, layer id on LYW bits, selected pixel}, captured on pxl_cen.
REQ-014 Read sequencer states: IDLE and READ. On pxl_cen, go to READ with lane 0. Issue one lane per clk, 0..NB-1. RAM latency is 1 clk; lane n data is stored on the following clk. After NB stores, return to IDLE.
REQ-015 Colour word C[3*CW-1:0] = {R,G,B}; lane n carries C[8n+7:8n]; bits above 3*CW are ignored.
REQ-016 On each pxl_cen, outputs take the word assembled in the previous pixel: 2-pixel latency from lyr_pxl to colour. LHBL_dly and LVBL_dly get the same 2-pixel delay.
REQ-017 Blanking: if the delayed LHBL or LVBL is low at the output update, red, green and blue load 0.
REQ-018 Overrun: if pxl_cen arrives while in READ, restart at lane 0 and set seq_ovf. Unread lanes keep stale bytes. seq_ovf clears only on reset.
REQ-019 Simultaneous CPU write and video read of the same byte: the video read returns the old data.

Reset
REQ-020 With rst_n low at a clk edge: red, green, blue, LHBL_dly, LVBL_dly, seq_ovf = 0; sequencer IDLE; assembly registers 0; palette contents undefined and not cleared.
REQ-021 Reset has priority over pxl_cen.

Configuration
REQ-022 JTFRAME_PAL_SHADOW_EN defined: a layer-0 pixel equal to 2^LW-2 is a shadow. It is skipped by the priority logic. The colour of the next selected layer is output with each channel shifted right by 1; the shadow flag is delayed with the pixel.
REQ-023 JTFRAME_PAL_SHADOW_EN undefined: pixel 2^LW-2 is an ordinary colour; no shadow logic is present.

Structure
REQ-024 Package jtframe_pal_pkg holds the NB/LYW/EW derivation functions, the lane-count constant 4 and the shadow code function.
REQ-025 The priority encoder is sub-module jtframe_pal_prio (LAYERS, LW, TW): combinational select plus layer id; palette RAM is jtframe_dual_ram.

Verification
REQ-026 CW=4, LAYERS=2, pxl_cen every 4 clk. Write entry 0x005: lane0=0x5A, lane1=0x03. Layer0=0x05, layer1=0x0F, LVBL=LHBL=1 -> two pixels later R=3, G=5, B=A.
REQ-027 Layer0=0x1F (transparent), layer1=0x22, pal_bank=1 -> colour of entry {1,1,0x22} appears.
REQ-028 CW=8, NB=3, pxl_cen every 3 clk -> seq_ovf=1 and lane 2 stale. With pxl_cen every 5 clk after reset -> seq_ovf stays 0.
REQ-029 LVBL=0 for the input pixel -> two pixels later RGB=0 and LVBL_dly=0.
REQ-030 Shadow build: layer0=0xFE, layer1 entry colour R=F, G=8, B=2 -> output R=7, G=4, B=1. Non-shadow build -> colour of entry {0,0,0xFE}.
REQ-031 rst_n low mid-READ for 1 clk -> all outputs 0 next clk; a CPU read of lane 3 returns 0x00.
